// File: rtl/relu_requant.sv
// ---------------------------------------------------------------------------
// relu_requant
//   Post-convolution requantisation stage feeding max-pooling. Streams N wide
//   signed convolution sums out of accumulator memory, applies
//   dp = sat(relu((qp + bias) >>> shift)) and writes the SIZE_1-bit result to
//   pixel memory starting at memstartzap.
//
// Build option: LEAKY_RELU_EN
//   Defined   : negative t becomes t>>>3, saturated low at -2^(SIZE_1-1).
//   Undefined : plain ReLU (negative t becomes 0).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   relu_en         run request (level); dropping it aborts or acknowledges STOP
//   memstartp       source base address       memstartzap  destination base
//   matrix2         element count N (0..1023)
//   bias, shift     signed bias and arithmetic right-shift amount
//   read_addressp   source read address       re           read enable
//   qp              read data, valid 2 edges after its address was registered
//   write_addressp  destination address       we           write strobe
//   dp              signed output pixel       STOP         run complete
// ---------------------------------------------------------------------------
module relu_requant #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_2           = 22,
    parameter int SIZE_address_pix = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        relu_en,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    input  logic [9:0]                  matrix2,
    input  logic signed [SIZE_2-1:0]    bias,
    input  logic [3:0]                  shift,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic                        re,
    input  logic signed [SIZE_2-1:0]    qp,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic                        we,
    output logic signed [SIZE_1-1:0]    dp,
    output logic                        STOP
);

    localparam int AW = SIZE_address_pix;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [SIZE_2:0] L_MAX = (SIZE_2+1)'((2 ** (SIZE_1 - 1)) - 1);
    localparam logic signed [SIZE_2:0] L_MIN = -L_MAX - 1;

    logic [1:0]               r_state;
    logic [9:0]               r_rcnt;     // reads issued so far
    logic [9:0]               r_wcnt;     // writes issued so far
    logic [9:0]               r_n;
    logic [AW-1:0]            r_base;
    logic [AW-1:0]            r_zap;
    logic signed [SIZE_2-1:0] r_bias;
    logic [3:0]               r_shift;
    logic                     r_v1;       // re delayed one edge: qp is valid next edge

    // Transfer function. Sum is one bit wider than the operands so it cannot
    // overflow; the shift is a floor (arithmetic) shift.
    logic signed [SIZE_2:0]   w_sum;
    logic signed [SIZE_2:0]   w_shr;
    logic signed [SIZE_1-1:0] w_f;

    assign w_sum = $signed({qp[SIZE_2-1], qp}) + $signed({r_bias[SIZE_2-1], r_bias});
    assign w_shr = w_sum >>> r_shift;

`ifdef LEAKY_RELU_EN
    logic signed [SIZE_2:0]   w_lk;
    assign w_lk = w_shr >>> 3;
`endif

    always_comb begin
        w_f = '0;
        if (w_shr > L_MAX) begin
            w_f = L_MAX[SIZE_1-1:0];
        end else if (w_shr < 0) begin
`ifdef LEAKY_RELU_EN
            if (w_lk < L_MIN) w_f = L_MIN[SIZE_1-1:0];
            else              w_f = w_lk[SIZE_1-1:0];
`else
            w_f = '0;
`endif
        end else begin
            w_f = w_shr[SIZE_1-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rcnt         <= '0;
            r_wcnt         <= '0;
            r_n            <= '0;
            r_base         <= '0;
            r_zap          <= '0;
            r_bias         <= '0;
            r_shift        <= '0;
            r_v1           <= 1'b0;
            read_addressp  <= '0;
            write_addressp <= '0;
            dp             <= '0;
            re             <= 1'b0;
            we             <= 1'b0;
            STOP           <= 1'b0;
        end else if (!relu_en) begin
            // Abort / acknowledge: in-flight reads are discarded, addresses
            // and dp keep their last values.
            r_state <= S_IDLE;
            r_rcnt  <= '0;
            r_wcnt  <= '0;
            r_v1    <= 1'b0;
            re      <= 1'b0;
            we      <= 1'b0;
            STOP    <= 1'b0;
        end else begin
            // Write pipe runs independently of the FSM: every read issued
            // two edges ago turns into exactly one write now.
            r_v1 <= re;
            we   <= 1'b0;
            if (r_v1) begin
                we             <= 1'b1;
                write_addressp <= r_zap + AW'(r_wcnt);
                dp             <= w_f;
                r_wcnt         <= r_wcnt + 10'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_base  <= memstartp;
                    r_zap   <= memstartzap;
                    r_n     <= matrix2;
                    r_bias  <= bias;
                    r_shift <= shift;
                    if (matrix2 != 10'd0) begin
                        read_addressp <= memstartp;
                        re            <= 1'b1;
                        r_rcnt        <= 10'd1;
                        r_state       <= S_RUN;
                    end else begin
                        STOP    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_RUN: begin
                    if (r_rcnt == r_n) begin
                        re      <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        read_addressp <= r_base + AW'(r_rcnt);
                        r_rcnt        <= r_rcnt + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_wcnt == r_n) begin
                        STOP    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    STOP <= 1'b1;
                    re   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_requant.sv
// ---------------------------------------------------------------------------
// tb_relu_requant
//   Directed bench for relu_requant: a 2-edge-latency memory model drives qp,
//   every write strobe is logged (address, data, cycle) and compared against
//   hand-computed vectors. Expectations follow LEAKY_RELU_EN when defined.
// ---------------------------------------------------------------------------
module tb_relu_requant;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               relu_en = 1'b0;
    logic [12:0]        memstartp = '0;
    logic [12:0]        memstartzap = '0;
    logic [9:0]         matrix2 = '0;
    logic signed [21:0] bias = '0;
    logic [3:0]         shift = '0;
    logic [12:0]        read_addressp;
    logic               re;
    logic signed [21:0] qp = '0;
    logic [12:0]        write_addressp;
    logic               we;
    logic signed [10:0] dp;
    logic               STOP;

    logic signed [21:0] mem [0:8191];
    int cyc = 0;
    int nw  = 0;
    int wa [0:511];
    int wd [0:511];
    int wc [0:511];
    int n_tests = 0;
    int n_fail  = 0;

    relu_requant dut (
        .clk(clk), .rst(rst), .relu_en(relu_en),
        .memstartp(memstartp), .memstartzap(memstartzap), .matrix2(matrix2),
        .bias(bias), .shift(shift),
        .read_addressp(read_addressp), .re(re), .qp(qp),
        .write_addressp(write_addressp), .we(we), .dp(dp), .STOP(STOP)
    );

    always #5 clk = ~clk;

    // Memory model: address seen at edge P(k+1) -> data sampled by DUT at P(k+2).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        qp  <= mem[read_addressp];
    end

    always @(negedge clk) begin
        if (we && nw < 512) begin
            wa[nw] = int'(write_addressp);
            wd[nw] = int'(dp);
            wc[nw] = cyc;
            nw     = nw + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start(input int b, input int z, input int n, input int bi,
                         input int sh, output int c0);
        memstartp   = 13'(b);
        memstartzap = 13'(z);
        matrix2     = 10'(n);
        bias        = 22'(bi);
        shift       = 4'(sh);
        relu_en     = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
    endtask

    task automatic wait_stop(input int budget, output int sc);
        int k;
        k = 0;
        while (!STOP && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (!STOP) chk("stop_timeout", 0, 1);
        sc = cyc;
    endtask

    task automatic drop_en;
        @(negedge clk);
        relu_en = 1'b0;
        @(posedge clk); #1;
        chk("stop_clear", int'(STOP), 0);
    endtask

    initial begin
        int c0, sc, w0, w1, k;
        int e1 [4];
        int e2 [3];
        int e6 [4];
        int a6 [4];

        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[100] = 22'sd5;   mem[101] = -22'sd3;   mem[102] = 22'sd1023; mem[103] = 22'sd2000;
        mem[300] = 22'sd80;  mem[301] = 22'sd15;   mem[302] = -22'sd1000;
        mem[400] = -22'sd80; mem[401] = 22'sd7;    mem[402] = 22'sd3000; mem[403] = 22'sd0;
        for (int i = 0; i < 100; i++) mem[1000 + i] = 22'(i + 1);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_re",   int'(re), 0);
        chk("rst_we",   int'(we), 0);
        chk("rst_stop", int'(STOP), 0);
        chk("rst_ra",   int'(read_addressp), 0);
        chk("rst_wa",   int'(write_addressp), 0);
        chk("rst_dp",   int'(dp), 0);
        @(negedge clk);
        rst = 1'b0;

        // T1 basic
        @(negedge clk);
        e1 = '{5, 0, 1023, 1023};
        w0 = nw;
        start(100, 200, 4, 0, 0, c0);
        chk("t1_re_p0", int'(re), 1);
        chk("t1_ra_p0", int'(read_addressp), 100);
        wait_stop(40, sc);
        chk("t1_stop_cyc", sc, c0 + 6);
        chk("t1_nwrites", nw - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_wa%0d", i), wa[w0 + i], 200 + i);
            chk($sformatf("t1_wd%0d", i), wd[w0 + i], e1[i]);
            chk($sformatf("t1_wc%0d", i), wc[w0 + i], c0 + 2 + i);
        end
        chk("t1_re_done", int'(re), 0);
        drop_en();

        // T2 bias/shift
        @(negedge clk);
`ifdef LEAKY_RELU_EN
        e2 = '{16, -1, -32};
`else
        e2 = '{16, 0, 0};
`endif
        w0 = nw;
        start(300, 500, 3, -16, 2, c0);
        wait_stop(40, sc);
        chk("t2_nwrites", nw - w0, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_wd%0d", i), wd[w0 + i], e2[i]);
        drop_en();

        // T3 N=0
        @(negedge clk);
        w0 = nw;
        start(0, 0, 0, 0, 0, c0);
        chk("t3_stop", int'(STOP), 1);
        chk("t3_re", int'(re), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_stop_hold", int'(STOP), 1);
        chk("t3_nwrites", nw - w0, 0);
        drop_en();

        // T4 abort after 10 writes, then restart
        @(negedge clk);
        w0 = nw;
        start(1000, 2000, 100, 0, 0, c0);
        k = 0;
        while (nw - w0 < 10 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t4_reach10", nw - w0, 10);
        relu_en = 1'b0;
        @(posedge clk); #1;
        chk("t4_re_off", int'(re), 0);
        chk("t4_we_off", int'(we), 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t4_nwrites", nw - w0, 10);
        chk("t4_nostop", int'(STOP), 0);
        chk("t4_last_wa", wa[w0 + 9], 2009);
        @(negedge clk);
        w0 = nw;
        start(1000, 2000, 100, 0, 0, c0);
        wait_stop(200, sc);
        chk("t4r_nwrites", nw - w0, 100);
        chk("t4r_wa0", wa[w0], 2000);
        chk("t4r_wd0", wd[w0], 1);
        chk("t4r_wa99", wa[w0 + 99], 2099);
        chk("t4r_wd99", wd[w0 + 99], 100);
        chk("t4r_stop_cyc", sc, c0 + 102);
        drop_en();

        // T5 reset mid-run
        @(negedge clk);
        w0 = nw;
        start(100, 600, 20, 0, 0, c0);
        k = 0;
        while (nw - w0 < 3 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t5_reach3", nw - w0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_re",   int'(re), 0);
        chk("t5_rst_we",   int'(we), 0);
        chk("t5_rst_stop", int'(STOP), 0);
        chk("t5_rst_ra",   int'(read_addressp), 0);
        chk("t5_rst_wa",   int'(write_addressp), 0);
        chk("t5_rst_dp",   int'(dp), 0);
        @(negedge clk);
        chk("t5_nowrite_rst", nw - w0, 3);
        w1 = nw;
        rst = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        chk("t5_re_p0", int'(re), 1);
        chk("t5_ra_p0", int'(read_addressp), 100);
        wait_stop(60, sc);
        chk("t5_nwrites", nw - w1, 20);
        chk("t5_wa0", wa[w1], 600);
        chk("t5_wd0", wd[w1], 5);
        chk("t5_stop_cyc", sc, c0 + 22);
        drop_en();

        // T6 leaky vector and destination wrap
        @(negedge clk);
`ifdef LEAKY_RELU_EN
        e6 = '{-10, 7, 1023, 0};
`else
        e6 = '{0, 7, 1023, 0};
`endif
        a6 = '{8190, 8191, 0, 1};
        w0 = nw;
        start(400, 8190, 4, 0, 0, c0);
        wait_stop(40, sc);
        chk("t6_nwrites", nw - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_wa%0d", i), wa[w0 + i], a6[i]);
            chk($sformatf("t6_wd%0d", i), wd[w0 + i], e6[i]);
        end
        drop_en();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
